fetch_queue_ctrl: RTL and testbench
===================================

Name: fetch_queue_ctrl

Overview:
Parametrised next-generation instruction-fetch front end. It generates the fetch PC, accepts instruction words from the icache, and buffers fetched packets {pc, inst, len} in an internal FIFO of depth FQ_DEPTH toward the decode stage through a valid/ready handshake. Redirect sources are predict_fail, jalr resolve, branch prediction and JAL. A two-state FSM waits for JALR resolution, and a PC_RESET parameter sets the boot vector.

Parameters:
FQ_DEPTH, 4, packet FIFO entries; power of two, at least 2
PTR_W, $clog2(FQ_DEPTH), FIFO pointer width (derived)
PC_RESET, 32'h0, PC value loaded on reset
ALLOW_RVC, 1, 1 = honour inst_length (2/4-byte step); 0 = always step 4

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; 0 freezes all state
inst_available  in  1  icache hit; inst is valid for fetch_addr this cycle
inst  in  32  instruction word from icache
inst_length  in  1  1 = 32-bit, 0 = 16-bit
pd_jal  in  1  predecode: inst is JAL
pd_jalr  in  1  predecode: inst is JALR
pd_imm  in  32  predecode: sign-extended JAL offset
branch  in  1  predictor says taken for the current inst
branch_addr  in  32  predicted target
predict_fail  in  1  misprediction flush
fail_addr  in  32  restart PC
jalr_compute  in  1  JALR target resolved
jalr_addr  in  32  resolved JALR target
fetch_addr  out  32  PC to icache
out_valid  out  1  FIFO head valid
out_pc  out  32  head packet PC
out_inst  out  32  head packet instruction
out_len  out  1  head packet length
out_ready  in  1  decode consumes the head when out_valid & out_ready
fq_count  out  PTR_W+1  occupancy, for debug and perf counters

Behaviour:
- Reset (rst_in=1, synchronous): pc=PC_RESET, FIFO emptied (head=tail=0, count=0), state=RUN, out_valid=0, fq_count=0. out_pc, out_inst and out_len show the head entry contents, which are don't-care while out_valid=0. Reset overrides every other input, including rdy_in=0.
- rdy_in=0 with no reset: all registers hold; no push and no pop.
- fetch_addr = pc, combinational.
- step = (ALLOW_RVC && !inst_length) ? 2 : 4.
- push = inst_available & state==RUN & (count<FQ_DEPTH | pop) & !predict_fail & !jalr_compute. pop = out_valid & out_ready.
- A push writes {pc, inst, inst_length} at tail, and the next PC is chosen in this priority order:
  - pd_jalr: pc holds, state goes to WAIT_JALR.
  - branch: branch_addr.
  - pd_jal: pc + pd_imm, 32-bit wrap.
  - otherwise: pc + step, wrapping at 2^32.
- FSM:
  - RUN: fetch normally.
  - WAIT_JALR: no push; pc holds. jalr_compute moves pc to jalr_addr and state to RUN.
  - A jalr_compute arriving while in RUN also loads pc with jalr_addr. This is a spurious or early resolve and is tolerated.
- predict_fail, highest non-reset priority:
  - pc = fail_addr, FIFO flushed (count=0), state=RUN. Any pending JALR is younger and is squashed.
  - No push and no pop that cycle; out_ready is ignored.
  - If predict_fail and jalr_compute coincide, predict_fail wins and jalr_addr is dropped.
- FIFO rules:
  - Full (count==FQ_DEPTH) with pop=1 allows a simultaneous push.
  - Full with pop=0 blocks the push; pc and state hold.
  - Empty: out_valid=0; a push appears at the head the next cycle, so latency from icache to out_valid is 1 cycle.
  - Pointers wrap modulo FQ_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- Packet order is strict program-fetch order; no packet is duplicated or lost except on flush.

Decomposition:
- Shared package/macros: FSM state encodings (FS_RUN, FS_WAIT_JALR), packet width constant (PKT_W = 65), and the step constants.
- One natural sub-module, fetch_fifo: a parametrised sync FIFO (width PKT_W, depth FQ_DEPTH) with push, pop, flush, full, empty and count. PC/FSM logic stays in fetch_queue_ctrl.

Test Plan:
- Reset, then inst_available=1, 4-byte insts, out_ready=1 -> fetch_addr 0,4,8,C; out_pc follows 1 cycle later; fq_count stays ≤1.
- 16-bit inst at pc=0x10 (inst_length=0, ALLOW_RVC=1) -> next fetch_addr 0x12. With ALLOW_RVC=0 -> 0x14.
- FQ_DEPTH=4, out_ready=0, 6 cycles of hits -> fq_count=4, pc frozen at 0x10. Then out_ready=1 for one cycle -> pop and push in the same cycle, count stays 4, pc becomes 0x14.
- pd_jalr at pc=0x20 -> state WAIT_JALR, fetch_addr held at 0x20, no pushes. jalr_compute with jalr_addr=0x100 -> next fetch_addr 0x100, pushes resume.
- Same-cycle predict_fail (fail_addr=0x200) and jalr_compute (0x300) while in WAIT_JALR with 3 queued -> fetch_addr 0x200, fq_count=0, state RUN.
- pd_jal, pd_imm=-8 at pc=0x40 -> 0x38. branch=1, branch_addr=0x80 together with pd_jal -> 0x80. rdy_in=0 for 3 cycles mid-stream -> no state change.

Source files
------------

// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared types and constants for the fetch front end.
// Holds FSM encodings, packet layout and PC step sizes.
package fetch_queue_ctrl_pkg;

  typedef enum logic [0:0] {
    FS_RUN       = 1'b0,
    FS_WAIT_JALR = 1'b1
  } fq_state_e;

  localparam int PKT_W = 65;

  localparam logic [31:0] STEP_RVC = 32'd2;
  localparam logic [31:0] STEP_STD = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        len;
  } fq_pkt_t;

  // Compressed insts advance by 2 only when RVC is enabled.
  function automatic logic [31:0] pc_step(
    input logic rvc_ok,
    input logic len
  );
    return (rvc_ok && !len) ? STEP_RVC : STEP_STD;
  endfunction

endpackage

// File: rtl/fetch_queue_ctrl_fifo.sv
// Synchronous packet FIFO for the fetch queue.
// Power-of-two depth; pointers wrap naturally.
module fetch_fifo
  import fetch_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PKT_W,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [W-1:0]   wdata_i,
  output logic [W-1:0]   rdata_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_en;

  assign wr_en = en_i & ~flush_i & push_i;

  // Next pointer and occupancy from push/pop/flush.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (en_i) begin
      if (flush_i) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push_i) tail_d = tail_q + PTR_ONE;
        if (pop_i)  head_d = head_q + PTR_ONE;
        case ({push_i, pop_i})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Packet storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch front end: PC generation,
// redirect handling and packet queue to decode.
module fetch_queue_ctrl
  import fetch_queue_ctrl_pkg::*;
#(
  parameter int          FQ_DEPTH  = 4,
  parameter int          PTR_W     = $clog2(FQ_DEPTH),
  parameter logic [31:0] PC_RESET  = 32'h0,
  parameter int          ALLOW_RVC = 1
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           inst_available,
  input  logic [31:0]    inst,
  input  logic           inst_length,
  input  logic           pd_jal,
  input  logic           pd_jalr,
  input  logic [31:0]    pd_imm,
  input  logic           branch,
  input  logic [31:0]    branch_addr,
  input  logic           predict_fail,
  input  logic [31:0]    fail_addr,
  input  logic           jalr_compute,
  input  logic [31:0]    jalr_addr,
  output logic [31:0]    fetch_addr,
  output logic           out_valid,
  output logic [31:0]    out_pc,
  output logic [31:0]    out_inst,
  output logic           out_len,
  input  logic           out_ready,
  output logic [PTR_W:0] fq_count
);

  localparam logic RVC_OK = (ALLOW_RVC != 0);

  fq_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_en;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  fq_pkt_t     wpkt, rpkt;

  // A flush squashes both ends of the queue.
  assign pop  = rdy_in & ~fifo_empty & out_ready
              & ~predict_fail;
  assign push = rdy_in & inst_available & fetch_en
              & (~fifo_full | pop)
              & ~predict_fail & ~jalr_compute;

  assign wpkt = '{pc: pc_q, inst: inst, len: inst_length};

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .W     (PKT_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .en_i    (rdy_in),
    .flush_i (predict_fail),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wpkt),
    .rdata_o (rpkt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fq_count)
  );

  // State and PC registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= FS_RUN;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and PC: flush, then JALR resolve,
  // then the redirect carried by the pushed inst.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (rdy_in) begin
      if (predict_fail) begin
        state_d = FS_RUN;
        pc_d    = fail_addr;
      end else if (jalr_compute) begin
        state_d = FS_RUN;
        pc_d    = jalr_addr;
      end else if (push) begin
        if (pd_jalr) begin
          state_d = FS_WAIT_JALR;
        end else if (branch) begin
          pc_d = branch_addr;
        end else if (pd_jal) begin
          pc_d = pc_q + pd_imm;
        end else begin
          pc_d = pc_q + pc_step(RVC_OK, inst_length);
        end
      end
    end
  end

  // Outputs derived from state, PC and queue head.
  always_comb begin
    fetch_en   = 1'b0;
    case (state_q)
      FS_RUN:       fetch_en = 1'b1;
      FS_WAIT_JALR: fetch_en = 1'b0;
      default:      fetch_en = 1'b0;
    endcase
    fetch_addr = pc_q;
    out_valid  = ~fifo_empty;
    out_pc     = rpkt.pc;
    out_inst   = rpkt.inst;
    out_len    = rpkt.len;
  end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Self-checking bench for fetch_queue_ctrl.
// Directed scenarios plus random traffic vs a queue model.
module tb_fetch_queue_ctrl;

  localparam int D  = 4;
  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, ia, len, jal, jalr, br, pf, jc, ordy;
  logic [31:0] inst, imm, br_addr, f_addr, j_addr;

  logic [31:0] fa, opc, oinst;
  logic        ov, olen;
  logic [PW:0] cnt;
  logic [31:0] fa_b, opc_b, oinst_b;
  logic        ov_b, olen_b;
  logic [PW:0] cnt_b;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        len;
  } mpkt_t;

  mpkt_t       mq[$];
  logic [31:0] m_pc;
  bit          m_wait;

  fetch_queue_ctrl #(
    .FQ_DEPTH(D), .PC_RESET(32'h0), .ALLOW_RVC(1)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .inst_available(ia), .inst(inst),
    .inst_length(len), .pd_jal(jal), .pd_jalr(jalr),
    .pd_imm(imm), .branch(br), .branch_addr(br_addr),
    .predict_fail(pf), .fail_addr(f_addr),
    .jalr_compute(jc), .jalr_addr(j_addr),
    .fetch_addr(fa), .out_valid(ov), .out_pc(opc),
    .out_inst(oinst), .out_len(olen),
    .out_ready(ordy), .fq_count(cnt)
  );

  fetch_queue_ctrl #(
    .FQ_DEPTH(D), .PC_RESET(32'h0), .ALLOW_RVC(0)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .inst_available(ia), .inst(inst),
    .inst_length(len), .pd_jal(jal), .pd_jalr(jalr),
    .pd_imm(imm), .branch(br), .branch_addr(br_addr),
    .predict_fail(pf), .fail_addr(f_addr),
    .jalr_compute(jc), .jalr_addr(j_addr),
    .fetch_addr(fa_b), .out_valid(ov_b), .out_pc(opc_b),
    .out_inst(oinst_b), .out_len(olen_b),
    .out_ready(ordy), .fq_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit do_pop, do_push;
    if (rst) begin
      m_pc = 32'h0;
      mq.delete();
      m_wait = 0;
    end else if (!rdy) begin
    end else if (pf) begin
      m_pc = f_addr;
      mq.delete();
      m_wait = 0;
    end else begin
      do_pop  = (mq.size() > 0) && ordy;
      do_push = ia && !m_wait && !jc
             && (mq.size() < D || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{m_pc, inst, len});
        if (jalr)     m_wait = 1;
        else if (br)  m_pc = br_addr;
        else if (jal) m_pc = m_pc + imm;
        else          m_pc = m_pc + (len ? 32'd4 : 32'd2);
      end
      if (jc) begin
        m_pc = j_addr;
        m_wait = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst = 0; rdy = 1; ia = 0; len = 1; jal = 0;
    jalr = 0; br = 0; pf = 0; jc = 0; ordy = 0;
    inst = 0; imm = 0; br_addr = 0; f_addr = 0;
    j_addr = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1; rdy = 0; ia = 1; ordy = 1;
    cycle();
    cycle();
    total++;
    if (fa !== 32'h0) $display("FAIL reset_pc: got %h want 0", fa);
    else passed++;
    total++;
    if (ov !== 1'b0) $display("FAIL reset_valid: got %b want 0", ov);
    else passed++;
    total++;
    if (cnt !== 3'd0) $display("FAIL reset_count: got %0d want 0", cnt);
    else passed++;
    rst = 0;
  endtask

  task automatic test_sequential();
    do_reset();
    ia = 1; len = 1; ordy = 1;
    for (int i = 0; i < 4; i++) begin
      inst = $urandom;
      total++;
      if (fa !== 32'(4*i))
        $display("FAIL seq_fetch%0d: got %h want %h", i, fa, 4*i);
      else passed++;
      cycle();
      total++;
      if (ov !== 1'b1 || opc !== 32'(4*i))
        $display("FAIL seq_out%0d: got v=%b pc=%h want v=1 pc=%h",
                 i, ov, opc, 4*i);
      else passed++;
      total++;
      if (cnt > 3'd1) $display("FAIL seq_cnt%0d: got %0d want <=1", i, cnt);
      else passed++;
    end
  endtask

  task automatic test_rvc();
    do_reset();
    ia = 1; len = 1; ordy = 1;
    repeat (4) cycle();
    len = 0;
    cycle();
    total++;
    if (fa !== 32'h12) $display("FAIL rvc_step: got %h want 12", fa);
    else passed++;
    total++;
    if (fa_b !== 32'h14) $display("FAIL norvc_step: got %h want 14", fa_b);
    else passed++;
    len = 1;
  endtask

  task automatic test_full();
    do_reset();
    ia = 1; len = 1; ordy = 0;
    repeat (6) cycle();
    total++;
    if (cnt !== 3'd4 || fa !== 32'h10)
      $display("FAIL full_hold: got cnt=%0d pc=%h want cnt=4 pc=10", cnt, fa);
    else passed++;
    total++;
    if (opc !== 32'h0) $display("FAIL full_head: got %h want 0", opc);
    else passed++;
    ordy = 1;
    cycle();
    ordy = 0;
    total++;
    if (cnt !== 3'd4 || fa !== 32'h14 || opc !== 32'h4)
      $display("FAIL full_pushpop: got cnt=%0d pc=%h head=%h want 4 14 4",
               cnt, fa, opc);
    else passed++;
  endtask

  task automatic test_jalr();
    do_reset();
    ia = 1; len = 1; ordy = 1;
    repeat (8) cycle();
    jalr = 1;
    cycle();
    jalr = 0;
    total++;
    if (fa !== 32'h20 || opc !== 32'h20)
      $display("FAIL jalr_enter: got pc=%h head=%h want 20 20", fa, opc);
    else passed++;
    repeat (3) cycle();
    total++;
    if (fa !== 32'h20 || cnt !== 3'd0 || ov !== 1'b0)
      $display("FAIL jalr_wait: got pc=%h cnt=%0d v=%b want 20 0 0",
               fa, cnt, ov);
    else passed++;
    jc = 1; j_addr = 32'h100;
    cycle();
    jc = 0;
    total++;
    if (fa !== 32'h100 || cnt !== 3'd0)
      $display("FAIL jalr_resolve: got pc=%h cnt=%0d want 100 0", fa, cnt);
    else passed++;
    cycle();
    total++;
    if (ov !== 1'b1 || opc !== 32'h100 || fa !== 32'h104)
      $display("FAIL jalr_resume: got v=%b head=%h pc=%h want 1 100 104",
               ov, opc, fa);
    else passed++;
  endtask

  task automatic test_flush_collision();
    do_reset();
    ia = 1; len = 1; ordy = 0;
    repeat (2) cycle();
    jalr = 1;
    cycle();
    jalr = 0;
    cycle();
    total++;
    if (cnt !== 3'd3 || fa !== 32'h8)
      $display("FAIL flush_setup: got cnt=%0d pc=%h want 3 8", cnt, fa);
    else passed++;
    pf = 1; f_addr = 32'h200; jc = 1; j_addr = 32'h300; ordy = 1;
    cycle();
    pf = 0; jc = 0; ordy = 0;
    total++;
    if (fa !== 32'h200 || cnt !== 3'd0 || ov !== 1'b0)
      $display("FAIL flush_win: got pc=%h cnt=%0d v=%b want 200 0 0",
               fa, cnt, ov);
    else passed++;
    cycle();
    total++;
    if (ov !== 1'b1 || opc !== 32'h200 || fa !== 32'h204)
      $display("FAIL flush_run: got v=%b head=%h pc=%h want 1 200 204",
               ov, opc, fa);
    else passed++;
  endtask

  task automatic test_jal_branch();
    do_reset();
    ordy = 1;
    pf = 1; f_addr = 32'h40;
    cycle();
    pf = 0;
    ia = 1; jal = 1; imm = 32'hFFFF_FFF8;
    cycle();
    total++;
    if (fa !== 32'h38) $display("FAIL jal_target: got %h want 38", fa);
    else passed++;
    br = 1; br_addr = 32'h80;
    cycle();
    br = 0; jal = 0;
    total++;
    if (fa !== 32'h80) $display("FAIL branch_prio: got %h want 80", fa);
    else passed++;
  endtask

  task automatic test_rdy_hold();
    logic [31:0] exp_pc;
    int          exp_cnt;
    logic [31:0] exp_head;
    do_reset();
    ia = 1; len = 1; ordy = 0;
    repeat (2) cycle();
    exp_pc   = m_pc;
    exp_cnt  = mq.size();
    exp_head = mq[0].pc;
    rdy = 0; ordy = 1;
    for (int i = 0; i < 3; i++) begin
      pf = (i == 1); f_addr = 32'h500;
      cycle();
      total++;
      if (fa !== exp_pc || cnt !== (PW+1)'(exp_cnt) || opc !== exp_head)
        $display("FAIL rdy_hold%0d: got pc=%h cnt=%0d head=%h want %h %0d %h",
                 i, fa, cnt, opc, exp_pc, exp_cnt, exp_head);
      else passed++;
    end
    pf = 0; rdy = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(99) == 0);
      rdy     = ($urandom_range(9) != 0);
      ia      = ($urandom_range(3) != 0);
      len     = $urandom_range(1);
      inst    = $urandom;
      jalr    = ($urandom_range(11) == 0);
      br      = ($urandom_range(7) == 0);
      jal     = ($urandom_range(7) == 0);
      imm     = {{20{1'b1}}, 12'($urandom)} ^ 32'($urandom_range(1) << 31);
      br_addr = $urandom & 32'hFFFF_FFFE;
      pf      = ($urandom_range(19) == 0);
      f_addr  = $urandom & 32'hFFFF_FFFE;
      jc      = ($urandom_range(9) == 0);
      j_addr  = $urandom & 32'hFFFF_FFFE;
      ordy    = ($urandom_range(2) != 0);
      cycle();
      total++;
      if (fa !== m_pc || ov !== (mq.size() > 0)
          || cnt !== (PW+1)'(mq.size()))
        $display("FAIL rand%0d_state: got pc=%h v=%b cnt=%0d want %h %b %0d",
                 i, fa, ov, cnt, m_pc, mq.size() > 0, mq.size());
      else passed++;
      if (mq.size() > 0) begin
        total++;
        if (opc !== mq[0].pc || oinst !== mq[0].inst
            || olen !== mq[0].len)
          $display("FAIL rand%0d_head: got %h/%h/%b want %h/%h/%b",
                   i, opc, oinst, olen,
                   mq[0].pc, mq[0].inst, mq[0].len);
        else passed++;
      end
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    m_pc = 32'h0;
    m_wait = 0;
    test_reset();
    test_sequential();
    test_rvc();
    test_full();
    test_jalr();
    test_flush_collision();
    test_jal_branch();
    test_rdy_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
